// File: rtl/iob_native_arb2_if.sv
// IOb native bus bundle: valid/addr/wdata/wstrb request toward the slave, rdata/ready response back.
// The master modport is the requester's view and the slave modport is the responder's view.
interface iob_native_arb2_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                valid;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   rdata;
    logic                ready;

    modport master (output valid, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_native_arb2.sv
// Two-master round-robin arbiter sharing one IOb native slave; the winner's request is captured and held.
// Define ARB_TIMEOUT_EN to force completion (rdata all ones, timeout pulse) after TIMEOUT stalled BUSY cycles.
module iob_native_arb2 #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    iob_native_arb2_if.slave  m0,
    iob_native_arb2_if.slave  m1,
    iob_native_arb2_if.master s,
    output logic              grant,
    output logic              busy,
    output logic              timeout
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                done;
    logic                force_done;
    logic [DATA_W-1:0]   resp_data;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The limit is hit when this stalled cycle would take the count to TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d      = cnt_q;
        force_done = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!s.ready) begin
            if (cnt_q == CNT_LAST) begin
                force_done = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign force_done = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    // On a tie the master that was not served last wins.
                    grant_d = (m0.valid && m1.valid) ? ~last_q : m1.valid;
                    addr_d  = grant_d ? m1.addr  : m0.addr;
                    wdata_d = grant_d ? m1.wdata : m0.wdata;
                    wstrb_d = grant_d ? m1.wstrb : m0.wstrb;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s.ready || force_done) begin
                    done    = 1'b1;
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // Response reaches only the granted master, and only in its completion cycle.
    assign resp_data = force_done ? {DATA_W{1'b1}} : s.rdata;
    assign m0.ready  = done && !grant_q;
    assign m1.ready  = done && grant_q;
    assign m0.rdata  = m0.ready ? resp_data : '0;
    assign m1.rdata  = m1.ready ? resp_data : '0;

    assign busy    = (state_q == BUSY);
    assign grant   = grant_q;
    assign timeout = force_done;
    assign s.valid = busy;
    assign s.addr  = addr_q;
    assign s.wdata = wdata_q;
    assign s.wstrb = wstrb_q;
endmodule

// File: tb/tb_iob_native_arb2.sv
// Bench for iob_native_arb2: a directed vector table, hand-written reset/timeout sequences,
// and randomized traffic compared against a transaction-level arbiter model.
module tb_iob_native_arb2;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    logic rst;
    logic grant, busy, timeout;

    iob_native_arb2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    iob_native_arb2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
    iob_native_arb2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

    iob_native_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        v0;  logic [15:0] a0;  logic [31:0] wd0;  logic [3:0] ws0;
        logic        v1;  logic [15:0] a1;  logic [31:0] wd1;  logic [3:0] ws1;
        logic        sr;  logic [31:0] srd;
        logic        eb;  logic        eg;  logic [15:0] ea;   logic [31:0] ew; logic [3:0] es;
        logic        er0; logic [31:0] erd0; logic er1;        logic [31:0] erd1;
    } vec_t;

    vec_t tbl[18];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkCycle(input logic eb, input logic eg, input logic [15:0] ea,
                              input logic [31:0] ew, input logic [3:0] es,
                              input logic er0, input logic [31:0] erd0,
                              input logic er1, input logic [31:0] erd1, input logic eto);
        checkOutput("s_valid", s_if.valid, eb);
        checkOutput("busy", busy, eb);
        if (eb) checkOutput("grant", grant, eg);
        checkOutput("s_addr", s_if.addr, ea);
        checkOutput("s_wdata", s_if.wdata, ew);
        checkOutput("s_wstrb", s_if.wstrb, es);
        checkOutput("m0_ready", m0_if.ready, er0);
        checkOutput("m0_rdata", m0_if.rdata, erd0);
        checkOutput("m1_ready", m1_if.ready, er1);
        checkOutput("m1_rdata", m1_if.rdata, erd1);
        checkOutput("timeout", timeout, eto);
    endtask

    task automatic setInputs(input logic v0, input logic [15:0] a0, input logic [31:0] wd0,
                             input logic [3:0] ws0, input logic v1, input logic [15:0] a1,
                             input logic [31:0] wd1, input logic [3:0] ws1,
                             input logic sr, input logic [31:0] srd);
        m0_if.valid = v0; m0_if.addr = a0; m0_if.wdata = wd0; m0_if.wstrb = ws0;
        m1_if.valid = v1; m1_if.addr = a1; m1_if.wdata = wd1; m1_if.wstrb = ws1;
        s_if.ready  = sr; s_if.rdata = srd;
    endtask

    task automatic applyStimulus(input logic v0, input logic [15:0] a0, input logic [31:0] wd0,
                                 input logic [3:0] ws0, input logic v1, input logic [15:0] a1,
                                 input logic [31:0] wd1, input logic [3:0] ws1,
                                 input logic sr, input logic [31:0] srd);
        @(posedge clk);
        #1;
        setInputs(v0, a0, wd0, ws0, v1, a1, wd1, ws1, sr, srd);
    endtask

    // Transaction-level reference state for the random phase.
    bit          mb, mg, ml;
    logic [15:0] ma;
    logic [31:0] mw;
    logic [3:0]  ms;
    int          mc;
    bit          mv[2];
    logic [15:0] ra[2];
    logic [31:0] rw[2];
    logic [3:0]  rs[2];

    initial begin
        bit          sr, done, to, er0, er1;
        logic [31:0] srd, erd;
        int          nready, nidle;

        tbl[0]  = '{1'b1,16'h20,32'h11,4'hF, 1'b1,16'h30,32'h22,4'h0, 1'b1,32'hA0, 1'b0,1'b0,16'h00,32'h00,4'h0, 1'b0,32'h0,1'b0,32'h0};
        tbl[1]  = '{1'b1,16'h20,32'h11,4'hF, 1'b1,16'h30,32'h22,4'h0, 1'b1,32'hA1, 1'b1,1'b0,16'h20,32'h11,4'hF, 1'b1,32'hA1,1'b0,32'h0};
        tbl[2]  = '{1'b1,16'h20,32'h11,4'hF, 1'b1,16'h30,32'h22,4'h0, 1'b1,32'hA2, 1'b0,1'b0,16'h20,32'h11,4'hF, 1'b0,32'h0,1'b0,32'h0};
        tbl[3]  = '{1'b1,16'h20,32'h11,4'hF, 1'b1,16'h30,32'h22,4'h0, 1'b1,32'hA3, 1'b1,1'b1,16'h30,32'h22,4'h0, 1'b0,32'h0,1'b1,32'hA3};
        tbl[4]  = '{1'b1,16'h20,32'h11,4'hF, 1'b1,16'h30,32'h22,4'h0, 1'b1,32'hA4, 1'b0,1'b1,16'h30,32'h22,4'h0, 1'b0,32'h0,1'b0,32'h0};
        tbl[5]  = '{1'b1,16'h20,32'h11,4'hF, 1'b1,16'h30,32'h22,4'h0, 1'b1,32'hA5, 1'b1,1'b0,16'h20,32'h11,4'hF, 1'b1,32'hA5,1'b0,32'h0};
        tbl[6]  = '{1'b1,16'h20,32'h11,4'hF, 1'b1,16'h30,32'h22,4'h0, 1'b1,32'hA6, 1'b0,1'b0,16'h20,32'h11,4'hF, 1'b0,32'h0,1'b0,32'h0};
        tbl[7]  = '{1'b1,16'h20,32'h11,4'hF, 1'b1,16'h30,32'h22,4'h0, 1'b1,32'hA7, 1'b1,1'b1,16'h30,32'h22,4'h0, 1'b0,32'h0,1'b1,32'hA7};
        tbl[8]  = '{1'b0,16'h20,32'h11,4'hF, 1'b0,16'h30,32'h22,4'h0, 1'b0,32'h00, 1'b0,1'b1,16'h30,32'h22,4'h0, 1'b0,32'h0,1'b0,32'h0};
        tbl[9]  = '{1'b1,16'h10,32'h00,4'h0, 1'b0,16'h30,32'h22,4'h0, 1'b0,32'h00, 1'b0,1'b1,16'h30,32'h22,4'h0, 1'b0,32'h0,1'b0,32'h0};
        tbl[10] = '{1'b1,16'h10,32'h00,4'h0, 1'b0,16'h30,32'h22,4'h0, 1'b0,32'h00, 1'b1,1'b0,16'h10,32'h00,4'h0, 1'b0,32'h0,1'b0,32'h0};
        tbl[11] = '{1'b1,16'h10,32'h00,4'h0, 1'b0,16'h30,32'h22,4'h0, 1'b0,32'h00, 1'b1,1'b0,16'h10,32'h00,4'h0, 1'b0,32'h0,1'b0,32'h0};
        tbl[12] = '{1'b1,16'h10,32'h00,4'h0, 1'b0,16'h30,32'h22,4'h0, 1'b1,32'h12345678, 1'b1,1'b0,16'h10,32'h00,4'h0, 1'b1,32'h12345678,1'b0,32'h0};
        tbl[13] = '{1'b0,16'h10,32'h00,4'h0, 1'b0,16'h30,32'h22,4'h0, 1'b1,32'hDEADBEEF, 1'b0,1'b0,16'h10,32'h00,4'h0, 1'b0,32'h0,1'b0,32'h0};
        tbl[14] = '{1'b0,16'h10,32'h00,4'h0, 1'b1,16'h04,32'hAABBCCDD,4'h3, 1'b0,32'h00, 1'b0,1'b0,16'h10,32'h00,4'h0, 1'b0,32'h0,1'b0,32'h0};
        tbl[15] = '{1'b0,16'h10,32'h00,4'h0, 1'b0,16'h08,32'h00,4'hF, 1'b0,32'h00, 1'b1,1'b1,16'h04,32'hAABBCCDD,4'h3, 1'b0,32'h0,1'b0,32'h0};
        tbl[16] = '{1'b0,16'h10,32'h00,4'h0, 1'b0,16'h08,32'h00,4'hF, 1'b1,32'h55, 1'b1,1'b1,16'h04,32'hAABBCCDD,4'h3, 1'b0,32'h0,1'b1,32'h55};
        tbl[17] = '{1'b0,16'h10,32'h00,4'h0, 1'b0,16'h08,32'h00,4'hF, 1'b0,32'h00, 1'b0,1'b1,16'h04,32'hAABBCCDD,4'h3, 1'b0,32'h0,1'b0,32'h0};

        rst = 1'b1;
        setInputs(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0);
        #2;
        checkCycle(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("grant_reset", grant, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: tie after reset, strict alternation, delayed read, captured write.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].v0, tbl[i].a0, tbl[i].wd0, tbl[i].ws0,
                          tbl[i].v1, tbl[i].a1, tbl[i].wd1, tbl[i].ws1, tbl[i].sr, tbl[i].srd);
            @(negedge clk);
            checkCycle(tbl[i].eb, tbl[i].eg, tbl[i].ea, tbl[i].ew, tbl[i].es,
                       tbl[i].er0, tbl[i].erd0, tbl[i].er1, tbl[i].erd1, 1'b0);
        end

        // Serve m0 so that last points at m0, then reset in the middle of the next transaction.
        applyStimulus(1'b1, 16'h40, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkCycle(1'b0, 1'b0, 16'h04, 32'hAABBCCDD, 4'h3, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 16'h40, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 32'h66);
        @(negedge clk);
        checkCycle(1'b1, 1'b0, 16'h40, 32'h0, 4'h0, 1'b1, 32'h66, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 16'h44, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkCycle(1'b0, 1'b0, 16'h40, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 16'h44, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0);
            @(negedge clk);
            checkCycle(1'b1, 1'b0, 16'h44, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        end
        applyStimulus(1'b1, 16'h44, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 32'h77);
        #2;
        rst = 1'b1;
        #1;
        checkCycle(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("grant_midreset", grant, 1'b0);
        @(negedge clk);
        @(negedge clk);
        setInputs(1'b1, 16'h44, 32'h0, 4'h0, 1'b1, 16'h48, 32'h99, 4'h1, 1'b0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkCycle(1'b1, 1'b0, 16'h44, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 16'h44, 32'h0, 4'h0, 1'b1, 16'h48, 32'h99, 4'h1, 1'b1, 32'h88);
        @(negedge clk);
        checkCycle(1'b1, 1'b0, 16'h44, 32'h0, 4'h0, 1'b1, 32'h88, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 16'h44, 32'h0, 4'h0, 1'b1, 16'h48, 32'h99, 4'h1, 1'b0, 32'h0);
        @(negedge clk);
        checkCycle(1'b0, 1'b0, 16'h44, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 16'h44, 32'h0, 4'h0, 1'b1, 16'h48, 32'h99, 4'h1, 1'b1, 32'hAB);
        @(negedge clk);
        checkCycle(1'b1, 1'b1, 16'h48, 32'h99, 4'h1, 1'b0, 32'h0, 1'b1, 32'hAB, 1'b0);

        // Stalled slave: forced completion with the watchdog, endless wait without it.
        applyStimulus(1'b1, 16'h50, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkCycle(1'b0, 1'b0, 16'h48, 32'h99, 4'h1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            applyStimulus(1'b1, 16'h50, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0);
            @(negedge clk);
            checkCycle(1'b1, 1'b0, 16'h50, 32'h0, 4'h0, k == TMO, (k == TMO) ? 32'hFFFFFFFF : 32'h0,
                       1'b0, 32'h0, k == TMO);
        end
        applyStimulus(1'b0, 16'h50, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkCycle(1'b0, 1'b0, 16'h50, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`else
        nready = 0;
        nidle  = 0;
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(1'b1, 16'h50, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 32'h0);
            @(negedge clk);
            if (m0_if.ready !== 1'b0 || timeout !== 1'b0) nready++;
            if (busy !== 1'b1) nidle++;
        end
        checkOutput("stall_no_ready", nready, 0);
        checkOutput("stall_stays_busy", nidle, 0);
        applyStimulus(1'b1, 16'h50, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 32'h5A);
        @(negedge clk);
        checkCycle(1'b1, 1'b0, 16'h50, 32'h0, 4'h0, 1'b1, 32'h5A, 1'b0, 32'h0, 1'b0);
`endif

        // Random traffic against the reference model, starting from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        setInputs(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b0;
        mb = 1'b0; mg = 1'b0; ml = 1'b1; ma = '0; mw = '0; ms = '0; mc = 0;
        mv[0] = 1'b0; mv[1] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!mv[i] && $urandom_range(0, 1) == 1) mv[i] = 1'b1;
                ra[i] = 16'($urandom);
                rw[i] = $urandom;
                rs[i] = 4'($urandom);
            end
            sr  = ($urandom_range(0, 3) == 0);
            srd = $urandom;
            applyStimulus(mv[0], ra[0], rw[0], rs[0], mv[1], ra[1], rw[1], rs[1], sr, srd);
            @(negedge clk);
            done = mb && sr;
            to   = 1'b0;
`ifdef ARB_TIMEOUT_EN
            to = mb && !sr && (mc == TMO - 1);
`endif
            er0 = (done || to) && !mg;
            er1 = (done || to) && mg;
            erd = to ? 32'hFFFFFFFF : srd;
            checkCycle(mb, mg, ma, mw, ms, er0, er0 ? erd : 32'h0, er1, er1 ? erd : 32'h0, to);
            if (!mb) begin
                if (mv[0] || mv[1]) begin
                    mg = (mv[0] && mv[1]) ? !ml : mv[1];
                    ma = ra[mg]; mw = rw[mg]; ms = rs[mg];
                    mb = 1'b1;
                    mc = 0;
                end
            end else if (done || to) begin
                ml = mg;
                mb = 1'b0;
                mv[mg] = 1'b0;
            end else begin
                mc++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
